sync_memory: RTL and testbench

Parametrised synchronous simple-dual-port RAM, the next generation of the team's basic asynchronous-read memory. Adds a registered read with valid strobe, per-lane write mask, selectable read-during-write policy and an optional hardware clear sequence after reset. Intended for register files, caches and FIFO storage in the Illusion system.

---
 rtl/sync_memory.sv | 150 +++++++++++++++
 tb/tb_sync_memory.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sync_memory.sv
// ----------------------------------------------------------------------------
// sync_memory
//   Simple-dual-port synchronous RAM with a registered read port, per-lane
//   write mask, selectable read-during-write behaviour and an optional
//   post-reset clear sequence that zeroes every word.
//
// Ports
//   aClock          rising-edge clock for all state
//   aReset          synchronous, active-high reset
//   aReadEnable     read request
//   aReadAddress    read word address
//   anOutReadData   registered read data (holds while no read completes)
//   anOutReadValid  one-cycle strobe marking anOutReadData as fresh
//   aWriteAddress   write word address
//   aWriteData      write data
//   aWriteMask      lane i enables bits [i*BYTE_WIDTH +: BYTE_WIDTH]
//   aWriteEnable    write request
//   anOutBusy       clear sequence running; all requests are ignored
// ----------------------------------------------------------------------------
module sync_memory #(
   parameter int DEPTH          = 16,
   parameter int SIZE           = 16,
   parameter int BYTE_WIDTH     = 8,
   parameter bit WRITE_FIRST    = 1'b0,
   parameter bit CLEAR_ON_RESET = 1'b1,
   localparam int MASK_WIDTH    = DEPTH / BYTE_WIDTH,
   localparam int ADDR_WIDTH    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic                  aClock,
   input  logic                  aReset,
   input  logic                  aReadEnable,
   input  logic [ADDR_WIDTH-1:0] aReadAddress,
   output logic [DEPTH-1:0]      anOutReadData,
   output logic                  anOutReadValid,
   input  logic [ADDR_WIDTH-1:0] aWriteAddress,
   input  logic [DEPTH-1:0]      aWriteData,
   input  logic [MASK_WIDTH-1:0] aWriteMask,
   input  logic                  aWriteEnable,
   output logic                  anOutBusy
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   clear_count_r;
   logic [DEPTH-1:0]        mem_r [SIZE];
   logic                    busy_r;
   logic                    read_valid_r;
   logic [DEPTH-1:0]        read_data_r;

   logic                    rd_in_range_s;
   logic                    wr_in_range_s;
   logic                    same_addr_s;
   logic [DEPTH-1:0]        wr_old_s;
   logic [DEPTH-1:0]        wr_merged_s;
   logic [DEPTH-1:0]        rd_word_s;

   // Replace the enabled lanes of old_word with the matching lanes of new_word.
   function automatic logic [DEPTH-1:0] merge_lanes(
      input logic [DEPTH-1:0]      old_word,
      input logic [DEPTH-1:0]      new_word,
      input logic [MASK_WIDTH-1:0] mask
   );
      logic [DEPTH-1:0] result;
      result = old_word;
      for (int i = 0; i < MASK_WIDTH; i++) begin
         if (mask[i]) begin
            result[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
         end else begin
            result[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      return result;
   endfunction

   // Address decode, masked write merge and the word presented to the read register.
   always_comb begin
      rd_in_range_s = int'(aReadAddress) < SIZE;
      wr_in_range_s = int'(aWriteAddress) < SIZE;
      // Array reads are guarded so an out-of-range address never indexes past the end.
      if (wr_in_range_s) begin
         wr_old_s = mem_r[aWriteAddress];
      end else begin
         wr_old_s = {DEPTH{1'b0}};
      end
      wr_merged_s = merge_lanes(wr_old_s, aWriteData, aWriteMask);
      same_addr_s = aWriteEnable && wr_in_range_s && (aWriteAddress == aReadAddress);
      if (!rd_in_range_s) begin
         rd_word_s = {DEPTH{1'b0}};
      end else if (WRITE_FIRST && same_addr_s) begin
         // Forward the merged word so the read sees this edge's write.
         rd_word_s = wr_merged_s;
      end else begin
         rd_word_s = mem_r[aReadAddress];
      end
   end

   // Control FSM: clear sequence, write port and registered read port.
   always_ff @(posedge aClock) begin
      if (aReset) begin
         state_r       <= CLEAR_ON_RESET ? CLEAR : IDLE;
         busy_r        <= CLEAR_ON_RESET;
         clear_count_r <= {ADDR_WIDTH{1'b0}};
         read_data_r   <= {DEPTH{1'b0}};
         read_valid_r  <= 1'b0;
      end else begin
         case (state_r)
            CLEAR: begin
               mem_r[clear_count_r] <= {DEPTH{1'b0}};
               read_data_r          <= {DEPTH{1'b0}};
               read_valid_r         <= 1'b0;
               if (clear_count_r == LAST_ADDR) begin
                  state_r       <= IDLE;
                  busy_r        <= 1'b0;
                  clear_count_r <= {ADDR_WIDTH{1'b0}};
               end else begin
                  clear_count_r <= clear_count_r + ADDR_WIDTH'(1);
               end
            end
            IDLE: begin
               busy_r <= 1'b0;
               if (aWriteEnable && wr_in_range_s) begin
                  mem_r[aWriteAddress] <= wr_merged_s;
               end
               if (aReadEnable) begin
                  read_data_r  <= rd_word_s;
                  read_valid_r <= 1'b1;
               end else begin
                  read_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r      <= IDLE;
               busy_r       <= 1'b0;
               read_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign anOutReadData  = read_data_r;
   assign anOutReadValid = read_valid_r;
   assign anOutBusy      = busy_r;

endmodule

// File: tb/tb_sync_memory.sv
// ----------------------------------------------------------------------------
// tb_sync_memory
//   Two instances share one stimulus bus: instance 0 is SIZE=16 read-first,
//   instance 1 is SIZE=12 write-first. A reference model of each memory
//   predicts read results into a queue; a negedge monitor pops and compares
//   on every valid strobe, and also compares busy, valid and held data.
// ----------------------------------------------------------------------------
module tb_sync_memory;

   localparam int DW = 16;
   localparam int MW = 2;
   localparam int AW = 4;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          re;
   logic          we;
   logic [AW-1:0] raddr;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [MW-1:0] wmask;

   logic [DW-1:0] rdata0, rdata1;
   logic          valid0, valid1, busy0, busy1;

   sync_memory #(.DEPTH(16), .SIZE(16), .BYTE_WIDTH(8), .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)) u_mem_a (
      .aClock(clk), .aReset(rst), .aReadEnable(re), .aReadAddress(raddr),
      .anOutReadData(rdata0), .anOutReadValid(valid0), .aWriteAddress(waddr),
      .aWriteData(wdata), .aWriteMask(wmask), .aWriteEnable(we), .anOutBusy(busy0));

   sync_memory #(.DEPTH(16), .SIZE(12), .BYTE_WIDTH(8), .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b1)) u_mem_b (
      .aClock(clk), .aReset(rst), .aReadEnable(re), .aReadAddress(raddr),
      .anOutReadData(rdata1), .anOutReadValid(valid1), .aWriteAddress(waddr),
      .aWriteData(wdata), .aWriteMask(wmask), .aWriteEnable(we), .anOutBusy(busy1));

   // Reference model state
   int            size_of [2] = '{16, 12};
   bit            wf_of   [2] = '{1'b0, 1'b1};
   logic [DW-1:0] model_mem [2][16];
   int            busy_left [2];
   logic          exp_busy  [2];
   logic          exp_valid [2];
   logic [DW-1:0] hold      [2];
   logic [DW-1:0] exp_q0 [$];
   logic [DW-1:0] exp_q1 [$];
   bit            armed = 1'b0;

   int checks   = 0;
   int failures = 0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] r;
      for (int l = 0; l < MW; l++) begin
         r[l*8 +: 8] = m[l] ? new_w[l*8 +: 8] : old_w[l*8 +: 8];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic mon(input int i, input logic [DW-1:0] d, input logic v, input logic b);
      logic [DW-1:0] e;
      check($sformatf("busy%0d", i), {15'd0, b}, {15'd0, exp_busy[i]});
      check($sformatf("valid%0d", i), {15'd0, v}, {15'd0, exp_valid[i]});
      if (v === 1'b1) begin
         if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid%0d actual=1 required=0 at %0t", i, $time);
         end else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("rdata%0d", i), d, e);
            hold[i] = e;
         end
      end else begin
         check($sformatf("hold%0d", i), d, hold[i]);
      end
   endtask

   // Monitor: compares outputs half a cycle after each active edge
   always @(negedge clk) begin
      if (armed) begin
         mon(0, rdata0, valid0, busy0);
         mon(1, rdata1, valid1, busy1);
      end
   end

   // One clock of stimulus; the model predicts what each memory does at this edge.
   task automatic cycle(input logic r, input logic rd_en, input logic [AW-1:0] ra, input logic wr_en,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [MW-1:0] wm);
      logic          nb [2];
      logic          nv [2];
      logic [DW-1:0] e;
      rst = r; re = rd_en; raddr = ra; we = wr_en; waddr = wa; wdata = wd; wmask = wm;
      for (int i = 0; i < 2; i++) begin
         if (r) begin
            for (int a = 0; a < 16; a++) model_mem[i][a] = 16'h0000;
            busy_left[i] = size_of[i];
            nb[i] = 1'b1;
            nv[i] = 1'b0;
         end else if (busy_left[i] > 0) begin
            busy_left[i]--;
            nb[i] = (busy_left[i] > 0);
            nv[i] = 1'b0;
         end else begin
            nb[i] = 1'b0;
            nv[i] = rd_en;
            if (rd_en) begin
               if (int'(ra) >= size_of[i]) e = 16'h0000;
               else if (wf_of[i] && wr_en && wa == ra) e = merge(model_mem[i][ra], wd, wm);
               else e = model_mem[i][ra];
               if (i == 0) exp_q0.push_back(e);
               else exp_q1.push_back(e);
            end
            if (wr_en && int'(wa) < size_of[i]) model_mem[i][wa] = merge(model_mem[i][wa], wd, wm);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         exp_busy[i]  = nb[i];
         exp_valid[i] = nv[i];
         if (r) hold[i] = 16'h0000;
      end
      if (r) armed = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 2'b00);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      cycle(1'b0, 1'b1, a, 1'b0, 4'd0, 16'h0000, 2'b00);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
      cycle(1'b0, 1'b0, 4'd0, 1'b1, a, d, m);
   endtask

   initial begin
      rst = 1'b1; re = 1'b0; we = 1'b0; raddr = '0; waddr = '0; wdata = '0; wmask = '0;
      // Reset and clear, then read every address
      cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 2'b00);
      idle(17);
      for (int a = 0; a < 16; a++) rd(4'(a));
      idle(2);
      // Masked partial write
      wr(4'd3, 16'hBEEF, 2'b11);
      wr(4'd3, 16'h1234, 2'b01);
      rd(4'd3);
      idle(2);
      // Read during write on the same address
      wr(4'd5, 16'hAAAA, 2'b11);
      cycle(1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 16'h5555, 2'b11);
      rd(4'd5);
      idle(1);
      // Reset mid-clear; write during busy is lost
      wr(4'd2, 16'h7777, 2'b11);
      cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 2'b00);
      idle(7);
      cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 2'b00);
      wr(4'd2, 16'h9999, 2'b11);
      idle(17);
      rd(4'd2);
      idle(1);
      // Out-of-range write/read for the 12-word instance
      for (int a = 0; a < 16; a++) wr(4'(a), 16'(a) * 16'h0101, 2'b11);
      wr(4'd13, 16'hFFFF, 2'b11);
      for (int a = 0; a < 16; a++) rd(4'(a));
      idle(1);
      // Continuous reads after data = addr * 0x0101
      for (int a = 0; a < 16; a++) wr(4'(a), 16'(a) * 16'h0101, 2'b11);
      for (int a = 0; a < 16; a++) rd(4'(a));
      idle(1);
      // Randomised traffic with occasional resets
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 79) == 0), 1'($urandom), 4'($urandom), 1'($urandom),
               4'($urandom), 16'($urandom), 2'($urandom));
      end
      idle(20);
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         failures++;
         $display("FAIL pending_reads actual=%0d/%0d required=0/0", exp_q0.size(), exp_q1.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
